// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types and sizing helpers for the four-phase handshake source endpoint.
//   hs_state_e      handshake FSM states
//   tmo_width()     width of a phase counter able to hold 0..timeout (minimum 1 bit)
//   HS_TMO_W        phase counter width for the default timeout
package cdc_hs_pkg;

    typedef enum logic [1:0] {HS_IDLE, HS_REQ_HI, HS_REQ_LO} hs_state_e;

    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int HS_TIMEOUT_DEF = 1024;
    localparam int HS_TMO_W = tmo_width(HS_TIMEOUT_DEF);

endpackage

// File: rtl/cdc_hs_skid.sv
// cdc_hs_skid: one-entry pending word register sitting in front of the handshake hold register.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture in_data and mark the entry valid
//   unload       release the entry (load wins if both are set)
//   in_data      word to capture
//   data, vld    stored word and its valid flag
module cdc_hs_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] data,
    output logic         vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else begin
            vld <= load | (vld & ~unload);
            if (load) data <= in_data;
        end
    end

endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source-side endpoint of a four-phase req/ack clock-domain crossing.
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   upstream word stream (in_ready = pending slot free)
//   req_o, data_o          request and held data towards the CDC left side (both registered)
//   ack_i                  already-synchronized acknowledge from the CDC
//   busy                   handshake in flight or a word pending
//   xfer_cnt               completed handshakes, wrapping
//   err_timeout            sticky: a handshake phase lasted TIMEOUT cycles
//   err_proto              sticky: ack seen while idle
//   err_clr                clears both error flags; a simultaneous new error keeps the flag set
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int W       = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             req_o,
    input  logic             ack_i,
    output logic [W-1:0]     data_o,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err_timeout,
    output logic             err_proto,
    input  logic             err_clr
);

    localparam int TW = tmo_width(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    hs_state_e     state_q, state_d;
    logic [W-1:0]  hold_q, hold_d, pend_data;
    logic [TW-1:0] phase_q, phase_d;
    logic          pend_vld, pend_load, pend_unload;
    logic          req_q, accept, tmo_hit, proto_hit;

    cdc_hs_skid #(.W(W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pend_load),
        .unload  (pend_unload),
        .in_data (in_data),
        .data    (pend_data),
        .vld     (pend_vld)
    );

    assign in_ready = !pend_vld;
    assign accept   = in_valid && in_ready;
    assign req_o    = req_q;
    assign data_o   = hold_q;
    assign busy     = (state_q != HS_IDLE) || pend_vld;

    // hold_q is only reloaded on transitions into REQ_HI, so data_o cannot move
    // while the receiver may be sampling it.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pend_load   = 1'b0;
        pend_unload = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (accept) begin
                    state_d = HS_REQ_HI;
                    hold_d  = in_data;
                end
            end
            HS_REQ_HI: begin
                pend_load = accept;
                if (ack_i) state_d = HS_REQ_LO;
            end
            HS_REQ_LO: begin
                if (ack_i) begin
                    pend_load = accept;
                end else if (pend_vld) begin
                    state_d     = HS_REQ_HI;
                    hold_d      = pend_data;
                    pend_unload = 1'b1;
                end else if (accept) begin
                    state_d = HS_REQ_HI;
                    hold_d  = in_data;
                end else begin
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    // Phase counter restarts on every state change and saturates at TIMEOUT,
    // so the flag keeps asserting for as long as the phase stays stuck.
    always_comb begin
        phase_d   = (state_d != state_q) ? '0 :
                    (state_q != HS_IDLE && phase_q != TMAX) ? phase_q + 1'b1 : phase_q;
        tmo_hit   = (TIMEOUT != 0) && (state_q != HS_IDLE) && (state_d == state_q) && (phase_d == TMAX);
        proto_hit = (state_q == HS_IDLE) && ack_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HS_IDLE;
            req_q       <= 1'b0;
            hold_q      <= '0;
            phase_q     <= '0;
            xfer_cnt    <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= state_d == HS_REQ_HI;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            if (state_q == HS_REQ_HI && ack_i) xfer_cnt <= xfer_cnt + 1'b1;
            err_timeout <= tmo_hit | (err_timeout & ~err_clr);
            err_proto   <= proto_hit | (err_proto & ~err_clr);
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: self-checking bench for cdc_hs_tx with a table of per-cycle vectors and directed sequences.
module tb_cdc_hs_tx;

    localparam int W = 32;
    localparam int CNT_W = 16;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             req_o;
    logic             ack_i;
    logic [W-1:0]     data_o;
    logic             busy;
    logic [CNT_W-1:0] xfer_cnt;
    logic             err_timeout;
    logic             err_proto;
    logic             err_clr = 1'b0;

    logic             force_ack_en = 1'b1;
    logic             force_ack_val = 1'b0;
    logic             ack_m = 1'b0;
    int               ack_dly = 3;
    int               dcnt = 0;
    logic [W-1:0]     rx_q[$];

    int               n_chk = 0;
    int               n_fail = 0;
    int               stab_err = 0;
    int               exp_cnt = 0;
    logic             prev_ok = 1'b0;
    logic             prev_req = 1'b0;
    logic [W-1:0]     prev_data = '0;

    assign ack_i = force_ack_en ? force_ack_val : ack_m;

    always #5 clk = ~clk;

    cdc_hs_tx #(.W(W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .req_o       (req_o),
        .ack_i       (ack_i),
        .data_o      (data_o),
        .busy        (busy),
        .xfer_cnt    (xfer_cnt),
        .err_timeout (err_timeout),
        .err_proto   (err_proto),
        .err_clr     (err_clr)
    );

    // Receiver model: follows req_o after ack_dly cycles and records the word on each ack rise.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n || force_ack_en) begin
            ack_m = 1'b0;
            dcnt  = 0;
        end else if (ack_m != req_o) begin
            dcnt++;
            if (dcnt >= ack_dly) begin
                ack_m = req_o;
                dcnt  = 0;
                if (req_o) rx_q.push_back(data_o);
            end
        end else begin
            dcnt = 0;
        end
    end

    // data_o may only move on the edge where req_o rises.
    always @(negedge clk) begin
        if (rst_n && prev_ok && data_o != prev_data && !(req_o && !prev_req)) stab_err++;
        prev_ok   = rst_n;
        prev_req  = req_o;
        prev_data = data_o;
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        a;
        logic        c;
        logic        req;
        logic        rdy;
        logic        bsy;
        logic [31:0] dout;
        logic [15:0] cnt;
        logic        epr;
    } vec_t;

    vec_t tbl[18] = '{
        '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 16'd0, 1'b0},
        '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 16'd0, 1'b0},
        '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd0, 1'b0},
        '{1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 16'd1, 1'b0},
        '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 16'd1, 1'b0},
        '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 16'd1, 1'b0},
        '{1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 16'd2, 1'b0},
        '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 16'd2, 1'b0},
        '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22222222, 16'd3, 1'b0},
        '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33333333, 16'd3, 1'b0},
        '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333, 16'd4, 1'b0},
        '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333, 16'd4, 1'b0},
        '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333, 16'd4, 1'b1},
        '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33333333, 16'd4, 1'b1},
        '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33333333, 16'd4, 1'b0},
        '{1'b1, 32'h44444444, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 16'd4, 1'b1},
        '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44444444, 16'd5, 1'b0},
        '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44444444, 16'd5, 1'b0}
    };

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic a, input logic c);
        @(negedge clk);
        in_valid      = v;
        in_data       = d;
        force_ack_val = a;
        err_clr       = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int i;
        int guard;
        logic acc;
        logic saw_nr;

        // Reset held with in_valid asserted: nothing may be accepted.
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hFFFF0000;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_req", req_o, 1'b0);
            chk("rst_ready", in_ready, 1'b1);
        end
        chk("rst_cnt", xfer_cnt, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_errs", {err_timeout, err_proto}, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Cycle-by-cycle vectors with a hand-driven ack.
        force_ack_en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].v, tbl[k].d, tbl[k].a, tbl[k].c);
            chk($sformatf("tbl[%0d].req", k), req_o, tbl[k].req);
            chk($sformatf("tbl[%0d].ready", k), in_ready, tbl[k].rdy);
            chk($sformatf("tbl[%0d].busy", k), busy, tbl[k].bsy);
            chk($sformatf("tbl[%0d].data", k), data_o, tbl[k].dout);
            chk($sformatf("tbl[%0d].cnt", k), xfer_cnt, tbl[k].cnt);
            chk($sformatf("tbl[%0d].eproto", k), err_proto, tbl[k].epr);
            chk($sformatf("tbl[%0d].etmo", k), err_timeout, 1'b0);
        end
        exp_cnt = 5;

        // Single word, receiver answers after 3 cycles.
        @(negedge clk);
        force_ack_en = 1'b0;
        ack_dly      = 3;
        base         = rx_q.size();
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("single_req_rise", req_o, 1'b1);
        chk("single_data", data_o, 32'hDEADBEEF);
        wait_idle("single_idle");
        exp_cnt++;
        chk("single_cnt", xfer_cnt, 16'(exp_cnt));
        chk("single_rx_n", rx_q.size(), base + 1);
        chk("single_rx", (rx_q.size() > base) ? rx_q[base] : 32'hxxxxxxxx, 32'hDEADBEEF);

        // Stream of 8 words with continuous in_valid, receiver delay 2.
        ack_dly = 2;
        base    = rx_q.size();
        i       = 0;
        guard   = 0;
        saw_nr  = 1'b0;
        while (i < 8 && guard < 300) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'(i);
            acc      = in_ready;
            if (!in_ready) saw_nr = 1'b1;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        chk("stream_accepts", i, 8);
        chk("stream_backpressure", saw_nr, 1'b1);
        wait_idle("stream_idle");
        exp_cnt += 8;
        chk("stream_cnt", xfer_cnt, 16'(exp_cnt));
        chk("stream_rx_n", rx_q.size(), base + 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("stream_rx[%0d]", k), (base + k < rx_q.size()) ? rx_q[base + k] : 32'hxxxxxxxx, 32'(k));

        // Timeout with ack held low, then late completion and clear.
        @(negedge clk);
        force_ack_en = 1'b1;
        step(1'b1, 32'h0BADF00D, 1'b0, 1'b0);
        repeat (15) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("tmo_before", err_timeout, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("tmo_at16", err_timeout, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("tmo_no_abort", req_o, 1'b1);
        chk("tmo_data_held", data_o, 32'h0BADF00D);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        exp_cnt++;
        chk("tmo_ack_req", req_o, 1'b0);
        chk("tmo_cnt", xfer_cnt, 16'(exp_cnt));
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("tmo_idle", busy, 1'b0);
        chk("tmo_sticky", err_timeout, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("tmo_clr", err_timeout, 1'b0);

        // Ack while idle flags a protocol error but the next word still goes through.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("proto_set", err_proto, 1'b1);
        chk("proto_idle", busy, 1'b0);
        @(negedge clk);
        force_ack_val = 1'b0;
        force_ack_en  = 1'b0;
        base          = rx_q.size();
        step(1'b1, 32'hA5A55A5A, 1'b0, 1'b0);
        chk("proto_req", req_o, 1'b1);
        wait_idle("proto_idle_after");
        exp_cnt++;
        chk("proto_cnt", xfer_cnt, 16'(exp_cnt));
        chk("proto_rx", (rx_q.size() > base) ? rx_q[base] : 32'hxxxxxxxx, 32'hA5A55A5A);
        chk("proto_sticky", err_proto, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("proto_clr", err_proto, 1'b0);

        // Asynchronous reset in REQ_HI with a pending word.
        @(negedge clk);
        force_ack_en = 1'b1;
        step(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE0002, 1'b0, 1'b0);
        chk("mid_pend_full", in_ready, 1'b0);
        chk("mid_req", req_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", req_o, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data", data_o, 32'h0);
        chk("mid_rst_cnt", xfer_cnt, 16'd0);
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        force_ack_en = 1'b0;
        exp_cnt      = 0;
        base         = rx_q.size();
        step(1'b1, 32'hBEEF0003, 1'b0, 1'b0);
        wait_idle("mid_idle");
        repeat (10) @(posedge clk);
        #1;
        chk("mid_cnt", xfer_cnt, 16'd1);
        chk("mid_rx_n", rx_q.size(), base + 1);
        chk("mid_rx", (rx_q.size() > base) ? rx_q[base] : 32'hxxxxxxxx, 32'hBEEF0003);
        chk("mid_busy_final", busy, 1'b0);

        chk("data_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
